// File: rtl/riscv_pkg.sv
// Shared definitions for the data-memory access path.
// Holds the RV32I load/store funct3 width codes and the state encoding of the
// load/store unit FSM. Imported by load_store_unit and load_formatter.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/load_formatter.sv
// Combinational load-data formatter.
// Aligns the addressed byte/halfword of a 32-bit read word down to bit 0 and
// sign- or zero-extends it according to the RV32I load funct3.
// Ports:
//   rdata  [31:0] in  : raw word from memory (or cache)
//   offset [1:0]  in  : byte offset of the access within the word
//   funct3 [2:0]  in  : load width/sign code
//   result [31:0] out : extended value for writeback
module load_formatter
    import riscv_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (funct3)
            F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   result = {24'd0, shifted[7:0]};
            F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   result = {16'd0, shifted[15:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage of the single-cycle core.
// Accepts a load/store from decode, runs one valid/ready request plus a
// response wait on the data-memory bus, and returns formatted load data to
// the writeback mux. The core is stalled while a transaction is in flight.
// Ports:
//   clk, rst_n                 : clock (rising edge), async active-low reset
//   mem_req, mem_we, funct3    : access request, store flag, width/sign code
//   addr, store_data           : byte address (ALU result), rs2 value
//   load_result                : formatted load data to writeback
//   stall                      : freeze PC/pipeline while high
//   misaligned                 : alignment or illegal-funct3 fault
//   bus_error                  : one-cycle pulse when the response times out
//   dmem_req_valid/ready       : bus request handshake
//   dmem_addr/we/wstrb/wdata   : registered request fields
//   dmem_rsp_valid, dmem_rdata : bus response
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    output logic [31:0]       load_result,
    output logic              stall,
    output logic              misaligned,
    output logic              bus_error,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic              dmem_we,
    output logic [3:0]        dmem_wstrb,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_rsp_valid,
    input  logic [31:0]       dmem_rdata
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    lsu_state_t        state_reg, state_next;
    logic [15:0]       count_reg;
    logic [31:0]       load_result_reg;
    logic              bus_error_reg;
    logic [ADDR_W-1:0] dmem_addr_reg;
    logic              dmem_we_reg;
    logic [3:0]        dmem_wstrb_reg;
    logic [31:0]       dmem_wdata_reg;
    logic [2:0]        funct3_reg;
    logic [1:0]        offset_reg;

    logic              illegal_f3;
    logic              align_bad;
    logic              accept;
    logic              timeout;
    logic [3:0]        wstrb_fmt;
    logic [31:0]       wdata_fmt;
    logic [31:0]       load_fmt;

    // ---------------------------------------------------------------
    // Access legality (evaluated on the live decode inputs)
    // ---------------------------------------------------------------
    always_comb begin
        if (mem_we)
            illegal_f3 = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
        else
            illegal_f3 = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        // funct3[1:0] encodes the width for both signed and unsigned loads
        align_bad = ((funct3[1:0] == 2'b01) && addr[0]) ||
                    ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    end

    assign misaligned = mem_req && (illegal_f3 || align_bad);
    assign accept     = mem_req && !(illegal_f3 || align_bad);
    assign timeout    = (count_reg == TIMEOUT_LAST);

    // ---------------------------------------------------------------
    // Store lane formatting
    // ---------------------------------------------------------------
    always_comb begin
        wstrb_fmt = 4'b0000;
        wdata_fmt = 32'd0;
        if (mem_we) begin
            case (funct3[1:0])
                2'b00: begin
                    wstrb_fmt = 4'b0001 << addr[1:0];
                    wdata_fmt = {4{store_data[7:0]}};
                end
                2'b01: begin
                    wstrb_fmt = addr[1] ? 4'b1100 : 4'b0011;
                    wdata_fmt = {2{store_data[15:0]}};
                end
                2'b10: begin
                    wstrb_fmt = 4'b1111;
                    wdata_fmt = store_data;
                end
                default: begin
                    wstrb_fmt = 4'b0000;
                    wdata_fmt = 32'd0;
                end
            endcase
        end
    end

    load_formatter u_load_formatter (
        .rdata  (dmem_rdata),
        .offset (offset_reg),
        .funct3 (funct3_reg),
        .result (load_fmt)
    );

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // ---------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept)         state_next = REQ;
            REQ:  if (dmem_req_ready) state_next = WAIT;
            WAIT: if (dmem_rsp_valid || timeout) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------
    always_comb begin
        stall          = 1'b0;
        dmem_req_valid = 1'b0;
        case (state_reg)
            IDLE: stall = accept;
            REQ: begin
                stall          = 1'b1;
                dmem_req_valid = 1'b1;
            end
            WAIT: stall = 1'b1;
            default: stall = 1'b0;
        endcase
        // A faulting access must not leak stale data to writeback
        load_result = misaligned ? 32'd0 : load_result_reg;
    end

    assign bus_error  = bus_error_reg;
    assign dmem_addr  = dmem_addr_reg;
    assign dmem_we    = dmem_we_reg;
    assign dmem_wstrb = dmem_wstrb_reg;
    assign dmem_wdata = dmem_wdata_reg;

    // ---------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg       <= 16'd0;
            load_result_reg <= 32'd0;
            bus_error_reg   <= 1'b0;
            dmem_addr_reg   <= '0;
            dmem_we_reg     <= 1'b0;
            dmem_wstrb_reg  <= 4'b0000;
            dmem_wdata_reg  <= 32'd0;
            funct3_reg      <= 3'b000;
            offset_reg      <= 2'b00;
        end else begin
            bus_error_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        dmem_addr_reg  <= {addr[ADDR_W-1:2], 2'b00};
                        dmem_we_reg    <= mem_we;
                        dmem_wstrb_reg <= wstrb_fmt;
                        dmem_wdata_reg <= wdata_fmt;
                        funct3_reg     <= funct3;
                        offset_reg     <= addr[1:0];
                    end
                end
                REQ: begin
                    if (dmem_req_ready)
                        count_reg <= 16'd0;
                end
                WAIT: begin
                    if (dmem_rsp_valid) begin
                        if (!dmem_we_reg)
                            load_result_reg <= load_fmt;
                    end else if (timeout) begin
                        load_result_reg <= 32'd0;
                        bus_error_reg   <= 1'b1;
                    end else begin
                        count_reg <= count_reg + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (TIMEOUT_CYCLES = 8).
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req;
    logic        mem_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] load_result;
    logic        stall;
    logic        misaligned;
    logic        bus_error;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic [31:0] dmem_addr;
    logic        dmem_we;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(8), .ADDR_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .funct3         (funct3),
        .addr           (addr),
        .store_data     (store_data),
        .load_result    (load_result),
        .stall          (stall),
        .misaligned     (misaligned),
        .bus_error      (bus_error),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_addr      (dmem_addr),
        .dmem_we        (dmem_we),
        .dmem_wstrb     (dmem_wstrb),
        .dmem_wdata     (dmem_wdata),
        .dmem_rsp_valid (dmem_rsp_valid),
        .dmem_rdata     (dmem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
            $display("check %-22s observed=%h expected=%h ok", tag, observed, expected);
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load with ready and response both immediate; expects 3 stall cycles.
    task automatic fast_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] rdata, input logic [31:0] exp);
        mem_req = 1'b1; mem_we = 1'b0; funct3 = f3; addr = a;
        dmem_rdata = rdata; dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b1;
        #1;
        check({tag, "_stall_idle"}, 32'(stall), 32'd1);
        tick();  // REQ
        check({tag, "_valid"}, 32'(dmem_req_valid), 32'd1);
        check({tag, "_daddr"}, dmem_addr, {a[31:2], 2'b00});
        check({tag, "_wstrb"}, 32'(dmem_wstrb), 32'd0);
        check({tag, "_stall_req"}, 32'(stall), 32'd1);
        tick();  // WAIT
        check({tag, "_stall_wait"}, 32'(stall), 32'd1);
        tick();  // DONE
        check({tag, "_stall_done"}, 32'(stall), 32'd0);
        check({tag, "_result"}, load_result, exp);
        mem_req = 1'b0; dmem_rsp_valid = 1'b0;
        tick();  // IDLE
        check({tag, "_hold"}, load_result, exp);
    endtask

    initial begin
        rst_n = 1'b0; mem_req = 1'b0; mem_we = 1'b0; funct3 = 3'b000;
        addr = 32'd0; store_data = 32'd0; dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0; dmem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_load_result", load_result, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_valid", 32'(dmem_req_valid), 32'd0);
        check("rst_bus_error", 32'(bus_error), 32'd0);
        check("rst_daddr", dmem_addr, 32'd0);
        check("rst_wstrb", 32'(dmem_wstrb), 32'd0);
        check("rst_wdata", dmem_wdata, 32'd0);
        rst_n = 1'b1;
        tick();

        // Loads: byte from top lane, halfword unsigned/signed from upper half
        fast_load("lb",  3'b000, 32'h0000_1003, 32'h80FF_1234, 32'hFFFF_FF80);
        fast_load("lhu", 3'b101, 32'h0000_2002, 32'hBEEF_0000, 32'h0000_BEEF);
        fast_load("lh",  3'b001, 32'h0000_2002, 32'hBEEF_0000, 32'hFFFF_BEEF);

        // SB with ready held low for 4 cycles
        mem_req = 1'b1; mem_we = 1'b1; funct3 = 3'b000; addr = 32'h0000_3001;
        store_data = 32'h0000_00A5; dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
        tick();  // REQ
        for (int i = 0; i < 4; i++) begin
            check("sb_daddr", dmem_addr, 32'h0000_3000);
            check("sb_wstrb", 32'(dmem_wstrb), 32'b0010);
            check("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
            check("sb_we", 32'(dmem_we), 32'd1);
            check("sb_valid", 32'(dmem_req_valid), 32'd1);
            check("sb_stall", 32'(stall), 32'd1);
            tick();
        end
        dmem_req_ready = 1'b1;
        tick();  // WAIT
        check("sb_stall_wait", 32'(stall), 32'd1);
        check("sb_valid_wait", 32'(dmem_req_valid), 32'd0);
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b1; dmem_rdata = 32'h1111_1111;
        tick();  // DONE
        check("sb_stall_done", 32'(stall), 32'd0);
        check("sb_result_kept", load_result, 32'hFFFF_BEEF);
        mem_req = 1'b0; dmem_rsp_valid = 1'b0;
        tick();

        // SH to upper half
        mem_req = 1'b1; mem_we = 1'b1; funct3 = 3'b001; addr = 32'h0000_3006;
        store_data = 32'h1234_BEEF; dmem_req_ready = 1'b1;
        tick();  // REQ
        check("sh_wstrb", 32'(dmem_wstrb), 32'b1100);
        check("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
        check("sh_daddr", dmem_addr, 32'h0000_3004);
        tick();  // WAIT
        dmem_rsp_valid = 1'b1;
        tick();  // DONE
        check("sh_stall_done", 32'(stall), 32'd0);
        mem_req = 1'b0; dmem_rsp_valid = 1'b0;
        tick();

        // Faults: misaligned LW, illegal load funct3, illegal store funct3
        mem_req = 1'b1; mem_we = 1'b0; funct3 = 3'b010; addr = 32'h0000_4002;
        dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b1;
        #1;
        check("lw_mis_flag", 32'(misaligned), 32'd1);
        check("lw_mis_stall", 32'(stall), 32'd0);
        check("lw_mis_result", load_result, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("lw_mis_no_valid", 32'(dmem_req_valid), 32'd0);
            check("lw_mis_no_stall", 32'(stall), 32'd0);
        end
        funct3 = 3'b011; addr = 32'h0000_4000;
        #1;
        check("ld_f3_011", 32'(misaligned), 32'd1);
        mem_we = 1'b1; funct3 = 3'b100;
        #1;
        check("st_f3_100", 32'(misaligned), 32'd1);
        check("st_f3_100_stall", 32'(stall), 32'd0);
        mem_req = 1'b0; mem_we = 1'b0; dmem_rsp_valid = 1'b0;
        #1;
        check("fault_clear_result", load_result, 32'hFFFF_BEEF);
        tick();
        check("fault_no_valid", 32'(dmem_req_valid), 32'd0);

        // Timeout: LW with no response, 8 WAIT cycles then bus_error
        mem_req = 1'b1; mem_we = 1'b0; funct3 = 3'b010; addr = 32'h0000_5000;
        dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b0; dmem_rdata = 32'hDEAD_BEEF;
        tick();  // REQ
        tick();  // WAIT cycle 1
        check("to_wait1_stall", 32'(stall), 32'd1);
        for (int i = 2; i <= 8; i++) begin
            tick();
            check("to_wait_bus_error", 32'(bus_error), 32'd0);
            check("to_wait_stall", 32'(stall), 32'd1);
        end
        tick();  // DONE
        check("to_bus_error", 32'(bus_error), 32'd1);
        check("to_result", load_result, 32'd0);
        check("to_stall_done", 32'(stall), 32'd0);
        mem_req = 1'b0;
        tick();  // IDLE
        check("to_pulse_end", 32'(bus_error), 32'd0);
        check("to_idle_valid", 32'(dmem_req_valid), 32'd0);

        // LW aligned, then reset during a following WAIT
        fast_load("lw", 3'b010, 32'h0000_6000, 32'hCAFE_F00D, 32'hCAFE_F00D);
        mem_req = 1'b1; mem_we = 1'b0; funct3 = 3'b010; addr = 32'h0000_7000;
        dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b0;
        tick();  // REQ
        tick();  // WAIT
        check("rr_in_wait", 32'(stall), 32'd1);
        #2;
        rst_n = 1'b0;
        mem_req = 1'b0;
        #1;
        check("rr_result", load_result, 32'd0);
        check("rr_stall", 32'(stall), 32'd0);
        check("rr_valid", 32'(dmem_req_valid), 32'd0);
        check("rr_daddr", dmem_addr, 32'd0);
        check("rr_wstrb", 32'(dmem_wstrb), 32'd0);
        #1;
        rst_n = 1'b1;
        dmem_rsp_valid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rr_stray_result", load_result, 32'd0);
            check("rr_stray_stall", 32'(stall), 32'd0);
            check("rr_stray_valid", 32'(dmem_req_valid), 32'd0);
            check("rr_stray_berr", 32'(bus_error), 32'd0);
        end
        dmem_rsp_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Data-memory access stage feeding the load_result input of the writeback select mux.
- Takes load/store requests from decode/ALU (address = ALU result) and runs a valid/ready transaction on the data-memory bus.
- Returns sign- or zero-extended load data to writeback.
- Holds the single-cycle core with a stall signal while a transaction is outstanding.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in WAIT before the transaction aborts with bus_error (1..65535)
ADDR_W, 32, byte-address width

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
mem_req  input  1  current instruction is a load or store
mem_we  input  1  1 = store, 0 = load
funct3  input  3  RV32I width/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW)
addr  input  ADDR_W  byte address from ALU
store_data  input  32  rs2 value
load_result  output  32  formatted load data to writeback mux
stall  output  1  freeze PC/pipeline while high
misaligned  output  1  access fault: bad alignment or illegal funct3
bus_error  output  1  one-cycle pulse on timeout
dmem_req_valid  output  1  bus request valid
dmem_req_ready  input  1  bus accepts request
dmem_addr  output  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
dmem_we  output  1  store request
dmem_wstrb  output  4  byte enables
dmem_wdata  output  32  replicated store data
dmem_rsp_valid  input  1  response (load data or store ack)
dmem_rdata  input  32  read word

Behaviour:
- Reset (async, rst_n low): state IDLE; load_result=0, bus_error=0, dmem_req_valid=0, dmem_we=0, dmem_wstrb=0, dmem_addr=0, dmem_wdata=0, timeout counter=0. Reset mid-transaction abandons it; later stray dmem_rsp_valid is ignored.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE:
    - mem_req=1 and access legal -> REQ. Request fields are registered from the inputs on this edge and held stable until accepted.
    - Access illegal -> stay IDLE; no bus activity.
  - REQ: dmem_req_valid=1. On the edge where dmem_req_ready=1 -> WAIT; counter cleared.
  - WAIT:
    - dmem_rsp_valid=1 -> DONE. For loads, load_result <= formatted dmem_rdata. For stores, load_result is unchanged.
    - Otherwise the counter increments. On counter == TIMEOUT_CYCLES-1 -> DONE, load_result <= 0, bus_error pulses 1 for one cycle.
  - DONE: one cycle, stall=0, load_result valid; instruction retires -> IDLE.
- stall (combinational) = 1 when (IDLE and mem_req and legal) or REQ or WAIT; 0 otherwise.
- Minimum load latency: 3 cycles (IDLE accept, REQ with ready=1, WAIT with rsp=1), then DONE.
- dmem_rsp_valid is honoured only in WAIT. A response arriving in the same cycle as request acceptance is ignored; the bus must respond at least one cycle after acceptance.
- misaligned (combinational, meaningful only with mem_req=1) is asserted for:
  - LH/LHU/SH with addr[0]=1;
  - LW/SW with addr[1:0]≠0;
  - illegal funct3 (011, 110, 111 for loads; anything other than 000/001/010 for stores).
  - On fault: stall=0, load_result forced 0 that cycle.
- Store formatting:
  - SB: wstrb = 4'b0001<<addr[1:0], wdata = {4{store_data[7:0]}}.
  - SH: wstrb = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{store_data[15:0]}}.
  - SW: wstrb = 4'b1111, wdata = store_data.
  - Loads: wstrb = 0.
- Load formatting: shift dmem_rdata right by 8*addr[1:0] (registered offset), then:
  - LB: sign-extend bit 7; LBU: zero-extend;
  - LH: sign-extend bit 15; LHU: zero-extend;
  - LW: pass through.
- Back-to-back accesses: a new mem_req is sampled only in IDLE, so there is always one IDLE cycle after DONE.

Decomposition:
- Shared package (riscv_pkg) holds:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101;
  - the lsu_state_t enum (IDLE, REQ, WAIT, DONE).
- One combinational sub-module, load_formatter: inputs rdata, offset[1:0], funct3; output 32-bit extended value. It is shared with any future cache path.

Test Plan:
- LB from addr 0x1003, rdata=0x80FF_1234, ready/rsp immediate -> load_result=0xFFFF_FF80 in DONE, stall high 3 cycles, wstrb=0.
- LHU addr 0x2002, rdata=0xBEEF_0000 -> load_result=0x0000_BEEF. LH same stimulus -> 0xFFFF_BEEF.
- SB addr 0x3001, store_data=0x0000_00A5 -> dmem_addr=0x3000, wstrb=0010, wdata=0xA5A5_A5A5, dmem_we=1; ready held low 4 cycles -> request fields stable throughout, stall high until DONE.
- LW addr 0x4002 -> misaligned=1, stall=0, dmem_req_valid never rises.
- TIMEOUT_CYCLES=8, LW with no rsp -> bus_error single pulse after 8 WAIT cycles, load_result=0, returns to IDLE.
- rst_n pulsed low during WAIT, then rsp_valid=1 in IDLE -> all outputs 0, state IDLE, response ignored.
